// File: rtl/pc_stack_ctrl.sv
// pc_stack_ctrl: program-counter sequencer with a hardware return stack for a single-cycle core
module pc_stack_ctrl #(
   parameter int              PC_W      = 11,
   parameter int              STK_DEPTH = 16,
   parameter logic [PC_W-1:0] RESET_VEC = 11'h000,
   parameter logic [PC_W-1:0] IRQ_VEC   = 11'h004,
   parameter bit              STVREN    = 1'b0
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            stall,
   input  logic            irq_take,
   input  logic            ret,
   input  logic            call,
   input  logic            jump,
   input  logic [PC_W-1:0] target,
   input  logic            bra,
   input  logic [8:0]      bra_off,
   input  logic            skip,
   input  logic            flag_clr,
   output logic [PC_W-1:0] Rom_addr_out,
   output logic [4:0]      stk_depth,
   output logic            stk_ovf,
   output logic            stk_unf,
   output logic            stk_rst_req
);
   localparam int PTR_W = $clog2(STK_DEPTH);
   localparam int DEP_W = 5;
   localparam logic [DEP_W-1:0] FULL = DEP_W'(STK_DEPTH);

   logic [PC_W-1:0]  r_pc;
   logic [PTR_W-1:0] r_wp;
   logic [DEP_W-1:0] r_depth;
   logic             r_ovf;
   logic             r_unf;
   logic             r_rst_req;
   logic [PC_W-1:0]  r_stk [STK_DEPTH];

   logic             w_push;
   logic             w_pop;
   logic             w_ovf;
   logic             w_unf;
   logic             w_fault_rst;
   logic [PTR_W-1:0] w_wp_dec;
   logic [PC_W-1:0]  w_pc_inc;
   logic [PC_W-1:0]  w_push_val;
   logic [PC_W-1:0]  w_ret_addr;
   logic [PC_W-1:0]  w_bra_tgt;
   logic [PC_W-1:0]  w_pc_nxt;
   logic [PTR_W-1:0] w_wp_nxt;
   logic [DEP_W-1:0] w_depth_nxt;

   // Winning action decode, stack fault detection and next-state selection
   always_comb begin
      w_pc_inc    = r_pc + 1'b1;
      w_push      = irq_take | (~ret & call);
      w_pop       = ~irq_take & ret;
      w_push_val  = irq_take ? r_pc : w_pc_inc;
      w_wp_dec    = r_wp - 1'b1;
      w_ret_addr  = r_stk[w_wp_dec];
      w_bra_tgt   = w_pc_inc + {{(PC_W-9){bra_off[8]}}, bra_off};
      w_ovf       = w_push & (r_depth == FULL);
      w_unf       = w_pop & (r_depth == '0);
      w_fault_rst = STVREN & (w_ovf | w_unf);
      w_pc_nxt    = ((w_ovf & STVREN) | w_unf) ? RESET_VEC :
                    irq_take                   ? IRQ_VEC :
                    ret                        ? w_ret_addr :
                    (call | jump)              ? target :
                    bra                        ? w_bra_tgt :
                    skip                       ? r_pc + PC_W'(2) :
                                                 w_pc_inc;
      w_wp_nxt    = w_fault_rst        ? '0 :
                    w_push             ? r_wp + 1'b1 :
                    (w_pop & ~w_unf)   ? w_wp_dec :
                                         r_wp;
      w_depth_nxt = (w_ovf & STVREN)   ? '0 :
                    w_ovf              ? r_depth :
                    w_push             ? r_depth + 1'b1 :
                    (w_pop & ~w_unf)   ? r_depth - 1'b1 :
                                         r_depth;
   end

   // PC, pointer, depth and sticky flags; a fault set beats a simultaneous clear
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pc      <= RESET_VEC;
         r_wp      <= '0;
         r_depth   <= '0;
         r_ovf     <= 1'b0;
         r_unf     <= 1'b0;
         r_rst_req <= 1'b0;
      end else if (!stall) begin
         r_pc      <= w_pc_nxt;
         r_wp      <= w_wp_nxt;
         r_depth   <= w_depth_nxt;
         r_ovf     <= w_ovf | (r_ovf & ~flag_clr);
         r_unf     <= w_unf | (r_unf & ~flag_clr);
         r_rst_req <= w_fault_rst;
      end else begin
         r_rst_req <= 1'b0;
      end
   end

   // Return-stack storage; every push writes, overflow simply wraps onto the oldest entry
   always_ff @(posedge clk) begin
      if (!stall && w_push) r_stk[r_wp] <= w_push_val;
   end

   assign Rom_addr_out = r_pc;
   assign stk_depth    = r_depth;
   assign stk_ovf      = r_ovf;
   assign stk_unf      = r_unf;
   assign stk_rst_req  = r_rst_req;
endmodule
